matrix_loader: RTL and testbench
================================

Name: matrix_loader

Overview:
- Upstream feeder stage for the 8x8 byte matrix multiplier.
- Accepts a byte stream over a valid/ready handshake and packs it row-major into two flat matrix buses, A then B.
- Once both are full, it asserts Enable to the multiplier and holds it until the multiplier reports done.
- It then returns Enable low, waits for done to clear and re-arms for the next matrix pair.

Parameters:
- N, 8, matrix dimension (N x N elements)
- W, 8, element width in bits
- MAT_BITS, N*N*W (512), width of each flat matrix bus; derived, not overridable

Ports:
- Clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising edge of Clock)
- in_data  in  W  stream element
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  loader can accept an element this cycle
- A  out  MAT_BITS  matrix A; element (i,j) at bits [(i*N+j)*W +: W]
- B  out  MAT_BITS  matrix B; same packing as A
- Enable  out  1  start/hold request to the multiplier
- mult_done  in  1  done flag from the multiplier
- busy  out  1  high when state is RUN or RELEASE
- pair_count  out  8  number of completed multiplications, mod 256

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=LOAD_A, elem_cnt=0.
  - A=0, B=0, Enable=0, pair_count=0.
  - in_ready=1 on the first cycle after reset is released.
- Transfer: occurs on a rising edge where in_valid && in_ready. Only transfers advance elem_cnt. in_valid with in_ready=0 is ignored; no buffering.
- in_ready is combinational from state: 1 in LOAD_A and LOAD_B, 0 in RUN and RELEASE.
- LOAD_A:
  - Transfer k (k = 0..N*N-1) writes A[k*W +: W] <= in_data; elem_cnt increments.
  - On transfer k = N*N-1: elem_cnt <= 0, state <= LOAD_B.
- LOAD_B:
  - Same write rule, targeting B.
  - On the last transfer: state <= RUN and Enable <= 1 on the same edge.
  - Enable is therefore high in the first cycle after the final B byte is accepted.
- RUN:
  - Enable=1. A and B are held constant.
  - When mult_done==1 is sampled at an edge: Enable <= 0, pair_count <= pair_count+1 (wraps 255->0), state <= RELEASE.
  - Latency from last B transfer to Enable rise is 1 edge. From mult_done sampled high to Enable low is 1 edge.
- RELEASE:
  - Enable=0, in_ready=0. A and B are still held.
  - Stays in RELEASE while mult_done==1.
  - When mult_done==0 is sampled: state <= LOAD_A, elem_cnt <= 0.
  - This guarantees a stale done is never mistaken for the next result.
- Boundary conditions:
  - mult_done high during LOAD_A or LOAD_B is ignored; no state change and no count change.
  - mult_done already high on RUN entry is accepted at the first RUN edge. RUN then lasts 1 cycle, followed by RELEASE until done drops.
  - A and B keep their previous contents until overwritten element-by-element in the next load. Elements not yet rewritten retain old values.
  - Reset asserted in any state, including mid-load or in RUN with Enable high, takes effect at that edge. Partial matrices are discarded (A=B=0) and Enable drops immediately.
  - in_valid toggling arbitrarily (bubbles) only stretches the load; element order is unaffected.
- Widths: elem_cnt is ceil(log2(N*N)) bits (6 at default). There is no arithmetic on data; bytes are passed through unchanged.

Test Plan:
1. Reset, then stream bytes 1..64 continuously, then 65..128. Required: A[7:0]=1, A[511:504]=64, B[7:0]=65, B[511:504]=128. Enable rises 1 cycle after byte 128 is accepted. in_ready=0 from that edge.
2. Multiplier model asserts mult_done 20 cycles after Enable rises and holds it 3 cycles. Required: Enable falls 1 edge after done is first sampled; pair_count=1; busy stays high until done drops; in_ready returns 1 the cycle after done=0 is sampled.
3. Backpressure and bubbles: drive in_valid with a 1-on/2-off pattern for a full A and B load. Required: same A/B contents as scenario 1, and exactly 128 transfers counted.
4. Pulse mult_done=1 for 5 cycles mid-LOAD_A. Required: no state change, Enable stays 0, pair_count unchanged, elem_cnt continues correctly.
5. Assert reset (0) after 40 A bytes, and separately during RUN. Required in both cases: next cycle A=0, B=0, Enable=0, pair_count=0, in_ready=1; a fresh 128-byte load then completes normally.
6. Run 257 back-to-back matrix pairs with the done model from scenario 2. Required: pair_count wraps to 1, and Enable never rises while mult_done is still high from the previous pair.

Source files
------------

// File: rtl/matrix_loader.sv
// Feeder for the 8x8 byte matrix multiplier: packs a byte stream row-major into A then B,
// then raises Enable and holds it until the multiplier reports done.
module matrix_loader #(
  parameter  int N        = 8,
  parameter  int W        = 8,
  localparam int MAT_BITS = N*N*W
) (
  input  logic                Clock,
  input  logic                reset,
  input  logic [W-1:0]        in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [MAT_BITS-1:0] A,
  output logic [MAT_BITS-1:0] B,
  output logic                Enable,
  input  logic                mult_done,
  output logic                busy,
  output logic [7:0]          pair_count
);

  localparam int CW = (N*N > 1) ? $clog2(N*N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N*N-1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, RUN, RELEASE} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [MAT_BITS-1:0]   a_q, a_d, b_q, b_d;
  logic                  en_q, en_d;
  logic [7:0]            pair_q, pair_d;
  logic                  xfer;

  assign in_ready   = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign busy       = (state_q == RUN) || (state_q == RELEASE);
  assign xfer       = in_valid && in_ready;
  assign A          = a_q;
  assign B          = b_q;
  assign Enable     = en_q;
  assign pair_count = pair_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    en_d    = en_q;
    pair_d  = pair_q;
    case (state_q)
      LOAD_A: if (xfer) begin
        a_d[int'(cnt_q)*W +: W] = in_data;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = LOAD_B;
        end
      end
      LOAD_B: if (xfer) begin
        b_d[int'(cnt_q)*W +: W] = in_data;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = RUN;
          en_d    = 1'b1;
        end
      end
      RUN: if (mult_done) begin
        en_d    = 1'b0;
        pair_d  = pair_q + 8'd1;
        state_d = RELEASE;
      end
      // Wait out the old done so it is never taken as the next pair's result.
      RELEASE: if (!mult_done) begin
        cnt_d   = '0;
        state_d = LOAD_A;
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!reset) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      en_q    <= 1'b0;
      pair_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      en_q    <= en_d;
      pair_q  <= pair_d;
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: byte-array model of A/B and a pair counter, driven on negedges.
module tb_matrix_loader;
  localparam int NN = 64;
  localparam int MB = 512;

  logic          Clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MB-1:0] A, B;
  logic          Enable;
  logic          mult_done = 1'b0;
  logic          busy;
  logic [7:0]    pair_count;

  int total = 0;
  int bad = 0;

  logic [7:0] mA[NN];
  logic [7:0] mB[NN];
  int mdl_t = 0;
  int mdl_pairs = 0;
  int rise_viol = 0;
  logic en_prev = 1'b0;

  matrix_loader dut (
    .Clock(Clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .A(A), .B(B), .Enable(Enable), .mult_done(mult_done),
    .busy(busy), .pair_count(pair_count)
  );

  always #5 Clock = ~Clock;

  // Enable must never come up while done from the previous pair is still asserted.
  always @(posedge Clock) begin
    #1;
    if (Enable && !en_prev && mult_done) rise_viol++;
    en_prev = Enable;
  end

  task automatic tick();
    @(negedge Clock);
  endtask

  function automatic void mdl_clear();
    for (int k = 0; k < NN; k++) begin mA[k] = '0; mB[k] = '0; end
    mdl_t = 0;
    mdl_pairs = 0;
  endfunction

  function automatic void mdl_push(input logic [7:0] d);
    if (mdl_t < NN) mA[mdl_t] = d; else mB[mdl_t-NN] = d;
    mdl_t = (mdl_t + 1) % (2*NN);
  endfunction

  function automatic logic [MB-1:0] packA();
    logic [MB-1:0] r;
    for (int k = 0; k < NN; k++) r[k*8 +: 8] = mA[k];
    return r;
  endfunction

  function automatic logic [MB-1:0] packB();
    logic [MB-1:0] r;
    for (int k = 0; k < NN; k++) r[k*8 +: 8] = mB[k];
    return r;
  endfunction

  task automatic apply_reset();
    in_valid = 1'b0; mult_done = 1'b0; reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    mdl_clear();
  endtask

  task automatic stream(input int n, input bit rnd, input int base, input bit bubble,
                        output int got, output int cyc, output bit en_early);
    logic [7:0] d;
    bit v, x;
    got = 0; cyc = 0; en_early = 0;
    while (got < n && cyc < 4000) begin
      v = !bubble || (cyc % 3 == 0);
      d = rnd ? 8'($urandom) : 8'(base + got);
      in_valid = v; in_data = d;
      x = v && in_ready;
      if (Enable) en_early = 1;
      tick(); cyc++;
      if (x) begin mdl_push(d); got++; end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_mult(input int delay, input int hold);
    repeat (delay - 1) tick();
    mult_done = 1'b1;
    repeat (hold) tick();
    mult_done = 1'b0;
    mdl_pairs++;
    tick();
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_data = 8'hAA; reset = 1'b0;
    tick(); tick();
    in_valid = 1'b0;
    total++; if (A !== '0) begin bad++; $display("FAIL rst_A got=%h want=0", A); end
    total++; if (B !== '0) begin bad++; $display("FAIL rst_B got=%h want=0", B); end
    total++; if (Enable !== 1'b0) begin bad++; $display("FAIL rst_en got=%b want=0", Enable); end
    total++; if (pair_count !== 8'd0) begin bad++; $display("FAIL rst_pc got=%0d want=0", pair_count); end
    reset = 1'b1;
    tick();
    mdl_clear();
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL rst_ready got ready=%b busy=%b want 1/0", in_ready, busy); end
  endtask

  task automatic test_load();
    int got, cyc; bit early;
    stream(128, 0, 1, 0, got, cyc, early);
    total++; if (got !== 128 || cyc !== 128) begin bad++;
      $display("FAIL load_xfers got=%0d cyc=%0d want 128/128", got, cyc); end
    total++; if (early !== 0) begin bad++; $display("FAIL load_en_early got=1 want=0"); end
    total++; if (A[7:0] !== 8'd1 || A[511:504] !== 8'd64) begin bad++;
      $display("FAIL load_A_ends got=%0d,%0d want=1,64", A[7:0], A[511:504]); end
    total++; if (B[7:0] !== 8'd65 || B[511:504] !== 8'd128) begin bad++;
      $display("FAIL load_B_ends got=%0d,%0d want=65,128", B[7:0], B[511:504]); end
    total++; if (A !== packA() || B !== packB()) begin bad++;
      $display("FAIL load_AB got A=%h B=%h", A, B); end
    total++; if (Enable !== 1'b1 || in_ready !== 1'b0) begin bad++;
      $display("FAIL load_en got en=%b ready=%b want 1/0", Enable, in_ready); end
  endtask

  task automatic test_done_handshake();
    bit dropped = 0;
    repeat (19) begin tick(); if (Enable !== 1'b1) dropped = 1; end
    total++; if (dropped) begin bad++; $display("FAIL run_hold got en drop want held"); end
    mult_done = 1'b1;
    tick();
    mdl_pairs++;
    total++; if (Enable !== 1'b0 || pair_count !== 8'(mdl_pairs)) begin bad++;
      $display("FAIL done_en got en=%b pc=%0d want 0/%0d", Enable, pair_count, mdl_pairs); end
    tick(); tick();
    mult_done = 1'b0;
    total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++;
      $display("FAIL release_hold got busy=%b ready=%b want 1/0", busy, in_ready); end
    tick();
    total++; if (busy !== 1'b0 || in_ready !== 1'b1 || Enable !== 1'b0) begin bad++;
      $display("FAIL rearm got busy=%b ready=%b en=%b want 0/1/0", busy, in_ready, Enable); end
  endtask

  task automatic test_bubbles();
    int got, cyc; bit early;
    stream(128, 0, 1, 1, got, cyc, early);
    total++; if (got !== 128 || cyc !== 382) begin bad++;
      $display("FAIL bubble_xfers got=%0d cyc=%0d want 128/382", got, cyc); end
    total++; if (A[7:0] !== 8'd1 || B[511:504] !== 8'd128 || A !== packA() || B !== packB()) begin bad++;
      $display("FAIL bubble_AB got A=%h B=%h", A, B); end
    total++; if (Enable !== 1'b1 || early !== 0) begin bad++;
      $display("FAIL bubble_en got en=%b early=%b want 1/0", Enable, early); end
    do_mult(20, 3);
  endtask

  task automatic test_done_in_load();
    int got, cyc, g2; bit early;
    stream(20, 1, 0, 0, got, cyc, early);
    mult_done = 1'b1;
    stream(5, 1, 0, 0, g2, cyc, early);
    mult_done = 1'b0;
    total++; if (got + g2 !== 25 || cyc !== 5) begin bad++;
      $display("FAIL ld_done_xfers got=%0d cyc=%0d want 25/5", got + g2, cyc); end
    total++; if (Enable !== 1'b0 || busy !== 1'b0 || pair_count !== 8'(mdl_pairs)) begin bad++;
      $display("FAIL ld_done_state got en=%b busy=%b pc=%0d want 0/0/%0d", Enable, busy, pair_count, mdl_pairs); end
    total++; if (A !== packA() || B !== packB()) begin bad++;
      $display("FAIL ld_partial got A=%h want %h", A, packA()); end
    stream(103, 1, 0, 0, got, cyc, early);
    total++; if (got !== 103 || Enable !== 1'b1 || A !== packA() || B !== packB()) begin bad++;
      $display("FAIL ld_done_finish got=%0d en=%b", got, Enable); end
    do_mult(20, 3);
  endtask

  task automatic test_reset_mid();
    int got, cyc; bit early;
    stream(40, 1, 0, 0, got, cyc, early);
    reset = 1'b0;
    tick();
    total++; if (A !== '0 || B !== '0 || Enable !== 1'b0 || pair_count !== 8'd0 || in_ready !== 1'b1) begin bad++;
      $display("FAIL rst_midload got en=%b pc=%0d ready=%b A=%h", Enable, pair_count, in_ready, A); end
    reset = 1'b1;
    tick();
    mdl_clear();
    stream(128, 1, 0, 0, got, cyc, early);
    total++; if (got !== 128 || Enable !== 1'b1 || A !== packA() || B !== packB()) begin bad++;
      $display("FAIL rst_reload1 got=%0d en=%b", got, Enable); end
    do_mult(20, 3);
    stream(128, 1, 0, 0, got, cyc, early);
    reset = 1'b0;
    tick();
    total++; if (A !== '0 || B !== '0 || Enable !== 1'b0 || pair_count !== 8'd0 || in_ready !== 1'b1) begin bad++;
      $display("FAIL rst_run got en=%b pc=%0d ready=%b", Enable, pair_count, in_ready); end
    reset = 1'b1;
    tick();
    mdl_clear();
    stream(128, 1, 0, 0, got, cyc, early);
    total++; if (got !== 128 || Enable !== 1'b1 || A !== packA() || B !== packB()) begin bad++;
      $display("FAIL rst_reload2 got=%0d en=%b", got, Enable); end
    do_mult(20, 3);
  endtask

  task automatic test_back_to_back();
    int got, cyc, errs; bit early;
    apply_reset();
    rise_viol = 0;
    errs = 0;
    for (int p = 0; p < 257; p++) begin
      stream(128, 1, 0, 0, got, cyc, early);
      if (got != 128 || Enable !== 1'b1 || A !== packA() || B !== packB()) errs++;
      do_mult(20, 3);
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL b2b_loads got errs=%0d want=0", errs); end
    total++; if (pair_count !== 8'(mdl_pairs) || pair_count !== 8'd1) begin bad++;
      $display("FAIL b2b_wrap got pc=%0d want=1", pair_count); end
    total++; if (rise_viol !== 0) begin bad++;
      $display("FAIL b2b_stale_done got=%0d want=0", rise_viol); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_done_handshake();
    test_bubbles();
    test_done_in_load();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
